// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the UART transmit arbiter:
//   - CNT_W        : width of the frame cycle counter
//   - state_e      : arbiter state encoding (IDLE = 0, SEND = 1, WAIT = 2)
//   - calc_bps_cnt : clock cycles per serial bit time
//   - calc_gap_cnt : clock cycles reserved per frame before the next grant
package uart_pkg;

    localparam int unsigned CNT_W = 20;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2
    } state_e;

    function automatic int unsigned calc_bps_cnt(input int unsigned clk_fre,
                                                 input int unsigned bps);
        return clk_fre / bps;
    endfunction

    // 10 bit times of frame plus one bit time that absorbs the 2-cycle
    // start-edge detect latency of uart_tx and leaves some margin.
    function automatic int unsigned calc_gap_cnt(input int unsigned bps_cnt);
        return 11 * bps_cnt;
    endfunction

endpackage

// File: rtl/rr_arb4.sv
// rr_arb4
// Four-way combinational round-robin picker. Searches req from index ptr
// upward, wrapping 3 -> 0, and returns the first asserted bit as a one-hot
// grant (all zero when nothing is requested).
//   req [3:0] : request bits
//   ptr [1:0] : highest-priority index for this pick
//   gnt [3:0] : one-hot grant
module rr_arb4 (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic [3:0] gnt
);

    logic [1:0] idx;
    logic       found;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < 4; i++) begin
            // 2-bit addition wraps naturally from 3 back to 0
            idx = ptr + 2'(i);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arb.sv
// uart_tx_arb
// Round-robin arbiter that shares one downstream uart_tx between four byte
// requesters. A grant latches the byte, pulses uart_tx_en for EN_HOLD cycles
// and then holds off further grants until the serial frame has gone out.
//   sys_clk      : system clock (rising edge)
//   sys_rst_n    : asynchronous active-low reset
//   req_valid    : per-requester byte pending
//   req_data     : requester i byte in [8i+7:8i]
//   req_ready    : one-hot grant, only while idle
//   uart_tx_data : byte presented to uart_tx, held until the next grant
//   uart_tx_en   : start request to uart_tx
//   busy         : high while a byte is being sent or its frame is pending
//   grant_id     : index of the requester whose byte is being sent
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | no frame in flight; req_ready offers the round-robin pick
// SEND  | uart_tx_en high, counter counts EN_HOLD cycles from grant
// WAIT  | uart_tx_en low, counter runs on until the frame gap has elapsed
module uart_tx_arb
    import uart_pkg::*;
#(
    parameter int unsigned BPS     = 'd9_600,
    parameter int unsigned CLK_FRE = 'd50_000_000,
    parameter int unsigned EN_HOLD = 4
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic [3:0]  req_valid,
    input  logic [31:0] req_data,
    output logic [3:0]  req_ready,
    output logic [7:0]  uart_tx_data,
    output logic        uart_tx_en,
    output logic        busy,
    output logic [1:0]  grant_id
);

    localparam int unsigned BPS_CNT = calc_bps_cnt(CLK_FRE, BPS);
    localparam int unsigned GAP_CNT = calc_gap_cnt(BPS_CNT);

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] EN_LAST  = CNT_W'(EN_HOLD - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CNT - 1);

    if (EN_HOLD < 2 || EN_HOLD > 8) begin : g_bad_en_hold
        $error("uart_tx_arb: EN_HOLD must lie in 2..8");
    end

    if (GAP_CNT > (1 << CNT_W) - 1) begin : g_bad_gap_cnt
        $error("uart_tx_arb: GAP_CNT does not fit the frame counter");
    end

    state_e           state_q, state_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       data_q, data_d;
    logic [1:0]       gid_q, gid_d;

    logic [3:0]       gnt;
    logic [1:0]       gnt_idx;
    logic             accept;

    rr_arb4 u_rr_arb4 (
        .req (req_valid),
        .ptr (ptr_q),
        .gnt (gnt)
    );

    // Gated by reset as well so req_ready is low the instant reset asserts,
    // even though the state register already sits at IDLE.
    assign req_ready = (state_q == IDLE && sys_rst_n) ? gnt : 4'b0000;
    assign accept    = |(req_valid & req_ready);

    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < 4; i++) begin
            if (gnt[i]) begin
                gnt_idx = 2'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        data_d  = data_q;
        gid_d   = gid_q;
        // Saturate rather than wrap so a stalled frame can never alias
        // back into an early terminal count.
        cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

        case (state_q)
            IDLE: begin
                cnt_d = cnt_q;
                if (accept) begin
                    state_d = SEND;
                    cnt_d   = '0;
                    data_d  = req_data[8*gnt_idx +: 8];
                    gid_d   = gnt_idx;
                    ptr_d   = gnt_idx + 2'd1;
                end
            end
            SEND: begin
                if (cnt_q >= EN_LAST) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // Counter started at SEND entry, so IDLE is reached exactly
                // GAP_CNT cycles after the grant took effect.
                if (cnt_q >= GAP_LAST) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            gid_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            gid_q   <= gid_d;
        end
    end

    assign uart_tx_data = data_q;
    assign grant_id     = gid_q;
    assign uart_tx_en   = (state_q == SEND);
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_arb.sv
module tb_uart_tx_arb;

    localparam int unsigned CLK_FRE = 50_000_000;
    localparam int unsigned BPS     = 5_000_000;
    localparam int          EN_HOLD = 4;
    localparam int          GAP     = 110;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_ready;
    logic [7:0]  uart_tx_data;
    logic        uart_tx_en;
    logic        busy;
    logic [1:0]  grant_id;

    uart_tx_arb #(
        .BPS     (BPS),
        .CLK_FRE (CLK_FRE),
        .EN_HOLD (EN_HOLD)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .uart_tx_data (uart_tx_data),
        .uart_tx_en   (uart_tx_en),
        .busy         (busy),
        .grant_id     (grant_id)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: a grant at cycle T owns the link for GAP+1 cycles;
    // the start pulse covers the first EN_HOLD cycles after T.
    bit         m_has  = 1'b0;
    int         m_tacc = 0;
    int         m_ptr  = 0;
    logic [7:0] m_data = '0;
    logic [1:0] m_gid  = '0;

    always @(negedge sys_clk) begin
        int         d;
        bit         idle;
        bit         e_en;
        logic [3:0] e_ready;
        int         e_g;
        if (!sys_rst_n) begin
            m_has = 1'b0; m_ptr = 0; m_data = '0; m_gid = '0;
            check("rst_ready", req_ready, 4'b0000);
            check("rst_en", uart_tx_en, 1'b0);
            check("rst_busy", busy, 1'b0);
            check("rst_data", uart_tx_data, 8'h00);
            check("rst_gid", grant_id, 2'd0);
        end else begin
            d       = cyc - m_tacc;
            idle    = !m_has || d >= GAP + 1;
            e_en    = m_has && d >= 1 && d <= EN_HOLD;
            e_ready = '0;
            e_g     = -1;
            if (idle) begin
                for (int k = 0; k < 4; k++) begin
                    if (e_g < 0 && req_valid[(m_ptr + k) % 4]) e_g = (m_ptr + k) % 4;
                end
                if (e_g >= 0) e_ready[e_g] = 1'b1;
            end
            check("model_ready", req_ready, e_ready);
            check("model_en", uart_tx_en, e_en);
            check("model_busy", busy, !idle);
            check("model_data", uart_tx_data, m_data);
            check("model_gid", grant_id, m_gid);
            if (e_g >= 0) begin
                m_has  = 1'b1;
                m_tacc = cyc;
                m_ptr  = (e_g + 1) % 4;
                m_data = req_data[8*e_g +: 8];
                m_gid  = 2'(e_g);
            end
        end
    end

    task automatic wait_accept(output int t, output int g);
        t = -1000;
        g = -1;
        for (int k = 0; k < 400; k++) begin
            @(negedge sys_clk); #1;
            if ((req_valid & req_ready) != 4'b0000) begin
                t = cyc;
                for (int i = 0; i < 4; i++) if (req_ready[i]) g = i;
                return;
            end
        end
        tests++;
        fails++;
        $display("FAIL accept_timeout: no accept within 400 cycles, valid=0x%0h", req_valid);
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 300; k++) begin
            @(negedge sys_clk); #1;
            if (!busy) return;
        end
        tests++;
        fails++;
        $display("FAIL idle_timeout: busy still high after 300 cycles");
    endtask

    typedef struct {
        logic [3:0]  valid;
        logic [31:0] data;
        int          exp_g;
        logic [7:0]  exp_byte;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int t, g, ta, tb2, tprev, en_cnt, fall;

        // pointer evolves 0 -> 3 -> 0 -> 1 -> 1 -> 2 -> 1 -> 2 -> 0
        vecs[0] = '{4'b0100, 32'h00A5_0000, 2, 8'hA5};
        vecs[1] = '{4'b1001, 32'h3C00_00C3, 3, 8'h3C};
        vecs[2] = '{4'b1001, 32'h7E00_0081, 0, 8'h81};
        vecs[3] = '{4'b0001, 32'h0000_00F0, 0, 8'hF0};
        vecs[4] = '{4'b1110, 32'h1234_5678, 1, 8'h56};
        vecs[5] = '{4'b0011, 32'hDEAD_BEEF, 0, 8'hEF};
        vecs[6] = '{4'b0011, 32'hCAFE_BABE, 1, 8'hBA};
        vecs[7] = '{4'b1000, 32'h8000_0000, 3, 8'h80};

        repeat (3) @(posedge sys_clk);
        #1 sys_rst_n = 1'b1;

        for (int v = 0; v < 8; v++) begin
            @(posedge sys_clk); #1;
            req_valid = vecs[v].valid;
            req_data  = vecs[v].data;
            wait_accept(t, g);
            check("vec_grant", g, vecs[v].exp_g);
            @(posedge sys_clk); #1;
            req_valid = '0;
            en_cnt = 0;
            fall   = -1;
            for (int k = 0; k < 200 && fall < 0; k++) begin
                @(negedge sys_clk); #1;
                if (k == 0) begin
                    check("vec_data", uart_tx_data, vecs[v].exp_byte);
                    check("vec_gid", grant_id, vecs[v].exp_g);
                end
                if (uart_tx_en) en_cnt++;
                if (!busy) fall = cyc;
            end
            check("vec_en_cycles", en_cnt, EN_HOLD);
            check("vec_busy_fall", fall - t, GAP + 1);
        end

        // request raised mid-WAIT waits for the gap to close
        @(posedge sys_clk); #1;
        req_valid = 4'b0001;
        req_data  = 32'h0000_0055;
        wait_accept(ta, g);
        check("wait_first_grant", g, 0);
        @(posedge sys_clk); #1;
        req_valid = '0;
        for (int k = 0; k < 100 && cyc < ta + 50; k++) begin
            @(posedge sys_clk); #1;
        end
        req_valid = 4'b0010;
        req_data  = 32'h0000_6600;
        wait_accept(tb2, g);
        check("wait_late_grant", g, 1);
        check("wait_latency", tb2 - ta, GAP + 1);
        @(posedge sys_clk); #1;
        req_valid = '0;
        @(negedge sys_clk); #1;
        check("wait_data", uart_tx_data, 8'h66);
        wait_idle();

        // asynchronous reset mid-frame
        @(posedge sys_clk); #1;
        req_valid = 4'b0100;
        req_data  = 32'h0099_0000;
        wait_accept(ta, g);
        check("rstseq_grant", g, 2);
        @(posedge sys_clk); #1;
        req_valid = 4'b0110;
        for (int k = 0; k < 100 && cyc < ta + 20; k++) begin
            @(posedge sys_clk); #1;
        end
        check("rstseq_busy_before", busy, 1'b1);
        #2 sys_rst_n = 1'b0;
        #1;
        check("rstseq_busy", busy, 1'b0);
        check("rstseq_en", uart_tx_en, 1'b0);
        check("rstseq_ready", req_ready, 4'b0000);
        check("rstseq_data", uart_tx_data, 8'h00);
        check("rstseq_gid", grant_id, 2'd0);
        @(posedge sys_clk);
        @(posedge sys_clk);
        #3 sys_rst_n = 1'b1;
        wait_accept(t, g);
        check("rstseq_after_grant", g, 1);
        @(posedge sys_clk); #1;
        req_valid = '0;

        // all four continuously valid from a fresh reset
        @(posedge sys_clk); #3 sys_rst_n = 1'b0;
        @(posedge sys_clk); #3 sys_rst_n = 1'b1;
        req_valid = 4'b1111;
        req_data  = 32'h4433_2211;
        tprev = 0;
        for (int k = 0; k < 4; k++) begin
            wait_accept(t, g);
            check("all4_order", g, k);
            if (k > 0) check("all4_spacing", t - tprev, GAP + 1);
            tprev = t;
            @(negedge sys_clk); #1;
            check("all4_data", uart_tx_data, 8'(8'h11 * (k + 1)));
        end
        @(posedge sys_clk); #1;
        req_valid = '0;
        wait_idle();

        // randomized traffic, checked by the reference model every cycle
        for (int k = 0; k < 3000; k++) begin
            @(posedge sys_clk); #1;
            if ($urandom_range(0, 7) == 0) req_valid = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) req_data = $urandom;
        end
        @(posedge sys_clk); #1;
        req_valid = '0;
        wait_idle();
        @(negedge sys_clk); #1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 Parameter BPS, default 'd9_600, the serial baud rate; it SHALL match the downstream uart_tx instance.
REQ-002 Parameter CLK_FRE, default 'd50_000_000, the input clock frequency in Hz.
REQ-003 Parameter EN_HOLD, default 4, the number of cycles uart_tx_en is held high per byte (legal range 2..8).
REQ-004 sys_clk  input  1  system clock; the block SHALL use a single clock, rising edge only.
REQ-005 sys_rst_n  input  1  reset, asynchronous assertion, active-low.
REQ-006 req_valid  input  4  per-requester byte-pending flag; bit i belongs to requester i.
REQ-007 req_data  input  32  per-requester byte; requester i uses bits [8i+7:8i].
REQ-008 req_ready  output  4  one-hot grant; the byte transfers on a cycle where req_valid[i] and req_ready[i] are both high.
REQ-009 uart_tx_data  output  8  byte presented to uart_tx.
REQ-010 uart_tx_en  output  1  rising-edge start request to uart_tx.
REQ-011 busy  output  1  high whenever the state is not IDLE.
REQ-012 grant_id  output  2  index of the requester whose byte is currently being sent.

Function
REQ-013 The block SHALL define the localparams BPS_CNT = CLK_FRE/BPS and GAP_CNT = 11*BPS_CNT; GAP_CNT covers 10 bit times, the 2-cycle edge-detect latency of uart_tx, and margin.
REQ-014 The state machine SHALL have three states: IDLE, SEND and WAIT.
REQ-015 IDLE: req_ready SHALL be a combinational one-hot round-robin pick among the asserted req_valid bits, searching from ptr upward and wrapping 3->0; req_ready SHALL be 0 when no request is pending or when the state is not IDLE.
REQ-016 On an accept at cycle T the block SHALL, at T+1, register the byte into uart_tx_data and the index into grant_id, set ptr = grant+1 mod 4, enter SEND and clear the counter.
REQ-017 SEND: uart_tx_en SHALL be 1 for exactly EN_HOLD cycles (T+1 .. T+EN_HOLD), after which the block enters WAIT with uart_tx_en = 0.
REQ-018 WAIT: the counter SHALL run from SEND entry; the block SHALL return to IDLE at cycle T+1+GAP_CNT, so the earliest next accept is T+1+GAP_CNT.
REQ-019 uart_tx_data SHALL stay stable from T+1 until the next accept, including through IDLE.
REQ-020 A requester that drops req_valid while not granted SHALL simply be skipped, with no side effect.
REQ-021 Requests arriving during SEND or WAIT SHALL wait and SHALL NOT be lost, provided req_valid is held.
REQ-022 The cycle counter SHALL be 20 bits wide and SHALL saturate and never wrap within a frame; a GAP_CNT that does not fit in 20 bits is illegal.
REQ-023 If all four requests are valid continuously, grants SHALL be issued in the order 0,1,2,3,0,... .

Reset
REQ-024 While sys_rst_n = 0, and immediately on its assertion: state = IDLE, ptr = 0, counter = 0, uart_tx_data = 8'd0, uart_tx_en = 0, grant_id = 0, busy = 0, req_ready = 0.
REQ-025 A reset asserted mid-SEND or mid-WAIT SHALL abort the byte; the first grant after release SHALL start from requester 0.

Structure
REQ-026 The shared package uart_pkg SHALL hold the BPS_CNT/GAP_CNT calculation function and the state encoding (IDLE = 0, SEND = 1, WAIT = 2).
REQ-027 The round-robin picker SHALL be the sub-module rr_arb4 (inputs req[3:0], ptr[1:0]; output gnt[3:0] one-hot), purely combinational.
REQ-028 The top level SHALL instantiate only rr_arb4; uart_tx is instantiated beside the block, not inside it.

Verification (use CLK_FRE = 50_000_000, BPS = 5_000_000, so BPS_CNT = 10 and GAP_CNT = 110; EN_HOLD = 4)
REQ-029 Single byte: req_valid = 4'b0100 with byte 0xA5 at cycle T -> req_ready = 4'b0100 at T; uart_tx_en high T+1..T+4; grant_id = 2; busy falls at T+111; the paired uart_tx emits 0, bits 1,0,1,0,0,1,0,1 (LSB first), then 1.
REQ-030 All four requesters valid with bytes 0x11/0x22/0x33/0x44 -> accepts spaced 111 cycles apart in the order 0,1,2,3; the serial stream carries 0x11 0x22 0x33 0x44 with no frame overlap.
REQ-031 Wrap-around: after granting requester 3, requesters 3 and 0 both valid -> requester 0 is granted first.
REQ-032 A request asserted mid-WAIT (at cycle T+50) -> req_ready stays 0 until T+111, then the request is accepted.
REQ-033 Reset pulse at T+20 during a frame -> all outputs return to their reset values asynchronously; after release with requests 1 and 2 valid, requester 1 is granted.
